hop_ctrl: RTL and testbench
===========================

HOP_CTRL -- requirements
Module: hop_ctrl

Interface
REQ-001 SHALL have parameter HOP_DIS, default 48, meaning pixels travelled per completed hop.
REQ-002 SHALL have parameter HOP_STEPS, default 4, meaning animation strobes per hop; HOP_DIS SHALL be divisible by HOP_STEPS.
REQ-003 SHALL have parameter D_WIDTH, default 640, meaning display width in pixels.
REQ-004 SHALL have parameter D_HEIGHT, default 480, meaning display height in pixels.
REQ-005 SHALL have parameter SPR_SIZE, default 48, meaning sprite width and height in pixels.
REQ-006 SHALL have port i_clk, input, 1 bit: single clock for all logic.
REQ-007 SHALL have port i_rst_n, input, 1 bit: synchronous reset, active-low.
REQ-008 SHALL have port i_ani_stb, input, 1 bit: animation strobe, one i_clk cycle per frame.
REQ-009 SHALL have port i_animate, input, 1 bit: motion permitted while high.
REQ-010 SHALL have ports i_up, i_down, i_left, i_right, input, 1 bit each: level direction buttons, already synchronised.
REQ-011 SHALL have ports i_start_x, i_start_y, input, 12 bits each: reset position of the sprite's top-left corner.
REQ-012 SHALL have ports o_x, o_y, output, 12 bits each: current sprite top-left position.
REQ-013 SHALL have port o_busy, output, 1 bit: high while a hop is in progress.
REQ-014 SHALL have port o_hop_done, output, 1 bit: one-cycle pulse when a hop completes.
REQ-015 SHALL have port o_blocked, output, 1 bit: one-cycle pulse when a request is rejected by bounds.
REQ-016 SHALL have port o_dir, output, 2 bits: direction of current/last hop (0 up, 1 down, 2 left, 3 right).

Function
REQ-017 SHALL rising-edge detect each button against its value in the previous cycle; only 0->1 transitions form requests.
REQ-018 SHALL resolve simultaneous edges by fixed priority up > down > left > right; lower-priority edges in that cycle are discarded.
REQ-019 SHALL implement FSM states IDLE, CHECK, STEP, DONE.
REQ-020 IDLE: on an accepted request, latch direction into o_dir and go to CHECK next cycle.
REQ-021 CHECK: compute target = position +/- HOP_DIS in 13-bit signed arithmetic; if target < 0, or x target > D_WIDTH-SPR_SIZE, or y target > D_HEIGHT-SPR_SIZE, pulse o_blocked, return to IDLE, position unchanged; else go to STEP with step counter 0.
REQ-022 STEP: on each cycle with i_ani_stb && i_animate, move position by HOP_DIS/HOP_STEPS in o_dir and increment the step counter; after HOP_STEPS moves go to DONE.
REQ-023 STEP SHALL hold position and counter when i_animate is low; a hop pauses, never aborts.
REQ-024 DONE: assert o_hop_done for exactly one cycle, then return to IDLE.
REQ-025 o_busy SHALL be high in CHECK, STEP and DONE, low in IDLE.
REQ-026 Button edges arriving outside IDLE SHALL be handled per REQ-031/REQ-032.
REQ-027 Position SHALL be a whole multiple of HOP_DIS away from start after every completed hop; no wrap-around occurs because of REQ-021.

Reset
REQ-028 When i_rst_n is low at a rising i_clk edge, state SHALL become IDLE, o_x/o_y load i_start_x/i_start_y, o_dir = 0, o_busy = 0, o_hop_done = 0, o_blocked = 0, step counter = 0, edge registers = current button levels (held buttons produce no request after reset), queue cleared.
REQ-029 Reset mid-hop SHALL abandon the hop with no o_hop_done pulse.
REQ-030 Reset SHALL take precedence over every other event in the same cycle.

Configuration
REQ-031 With macro HOP_QUEUE_EN defined, a one-entry request buffer SHALL capture the first accepted edge occurring while o_busy is high (later ones discarded until consumed); on leaving DONE or rejecting in CHECK, a buffered request SHALL go straight to CHECK without an IDLE cycle.
REQ-032 Without HOP_QUEUE_EN, edges while o_busy is high SHALL be dropped and no buffer logic exists.

Verification
REQ-033 Reset with start (296,432), pulse i_up, strobe every 4 cycles -> o_y 432,420,408,396,384; o_hop_done one cycle after last step; o_busy low after.
REQ-034 Start (0,0), pulse i_left -> o_blocked single pulse, o_x stays 0, no o_hop_done, o_busy high only for CHECK.
REQ-035 i_up and i_right rise same cycle -> o_dir = 0, only y changes by 48.
REQ-036 i_animate low for 10 strobes after 2 steps -> o_y frozen at start-24, resumes to start-48 after re-assert.
REQ-037 i_right pressed mid-hop: with HOP_QUEUE_EN, second hop starts immediately, o_x +96 total; without, o_x +48 only.
REQ-038 i_rst_n low during STEP with i_down held -> position back to start, no hop after release of reset until a new edge.

Source files
------------

// File: rtl/hop_ctrl.sv
// Sprite hop controller: turns button edges into fixed-distance, strobe-paced hops within the display bounds.
// Optional macro HOP_QUEUE_EN adds a one-entry buffer for a request that arrives while a hop is busy.
module hop_ctrl #(
    parameter int HOP_DIS   = 48,
    parameter int HOP_STEPS = 4,
    parameter int D_WIDTH   = 640,
    parameter int D_HEIGHT  = 480,
    parameter int SPR_SIZE  = 48
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic        i_up,
    input  logic        i_down,
    input  logic        i_left,
    input  logic        i_right,
    input  logic [11:0] i_start_x,
    input  logic [11:0] i_start_y,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_busy,
    output logic        o_hop_done,
    output logic        o_blocked,
    output logic [1:0]  o_dir
);

    localparam int                 STEP_PIX = HOP_DIS / HOP_STEPS;
    localparam int                 CNT_W    = $clog2(HOP_STEPS + 1);
    localparam logic signed [12:0] HOP_S    = 13'(HOP_DIS);
    localparam logic signed [12:0] X_MAX    = 13'(D_WIDTH - SPR_SIZE);
    localparam logic signed [12:0] Y_MAX    = 13'(D_HEIGHT - SPR_SIZE);
    localparam logic [11:0]        STEP_U   = 12'(STEP_PIX);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(HOP_STEPS - 1);

    typedef enum logic [1:0] {IDLE, CHECK, STEP, DONE} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t             state_q;
    dir_t               dir_q;
    logic [11:0]        x_q, y_q;
    logic [CNT_W-1:0]   step_q;
    logic               busy_q, done_q, blocked_q;
    logic [3:0]         btn_q;

    logic [3:0]         btn_now, edges;
    logic               req_valid;
    dir_t               req_dir;
    logic signed [12:0] pos_x, pos_y, tgt, lim;
    logic               hop_bad;

    assign btn_now = {i_right, i_left, i_down, i_up};
    assign edges   = btn_now & ~btn_q;

    always_comb begin
        req_valid = |edges;
        req_dir   = DIR_UP;
        if      (edges[0]) req_dir = DIR_UP;
        else if (edges[1]) req_dir = DIR_DOWN;
        else if (edges[2]) req_dir = DIR_LEFT;
        else if (edges[3]) req_dir = DIR_RIGHT;
    end

    // Bounds are checked only on the axis the hop moves along.
    always_comb begin
        pos_x = {1'b0, x_q};
        pos_y = {1'b0, y_q};
        tgt   = pos_y - HOP_S;
        lim   = Y_MAX;
        case (dir_q)
            DIR_UP:    begin tgt = pos_y - HOP_S; lim = Y_MAX; end
            DIR_DOWN:  begin tgt = pos_y + HOP_S; lim = Y_MAX; end
            DIR_LEFT:  begin tgt = pos_x - HOP_S; lim = X_MAX; end
            DIR_RIGHT: begin tgt = pos_x + HOP_S; lim = X_MAX; end
            default:   begin tgt = pos_y - HOP_S; lim = Y_MAX; end
        endcase
        hop_bad = (tgt < 13'sd0) || (tgt > lim);
    end

`ifdef HOP_QUEUE_EN
    logic q_valid_q;
    dir_t q_dir_q;
    logic pend_valid;
    dir_t pend_dir;

    // A buffered request wins over an edge arriving in the same cycle.
    always_comb begin
        pend_valid = q_valid_q | req_valid;
        pend_dir   = q_valid_q ? q_dir_q : req_dir;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            dir_q     <= DIR_UP;
            x_q       <= i_start_x;
            y_q       <= i_start_y;
            step_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            blocked_q <= 1'b0;
            // Buttons held through reset must not look like fresh presses afterwards.
            btn_q     <= btn_now;
`ifdef HOP_QUEUE_EN
            q_valid_q <= 1'b0;
            q_dir_q   <= DIR_UP;
`endif
        end else begin
            // NOTE: non-blocking throughout, so every branch sees the pre-edge state and later assignments override earlier defaults.
            btn_q     <= btn_now;
            done_q    <= 1'b0;
            blocked_q <= 1'b0;
`ifdef HOP_QUEUE_EN
            if (state_q != IDLE && req_valid && !q_valid_q) begin
                q_valid_q <= 1'b1;
                q_dir_q   <= req_dir;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        dir_q   <= req_dir;
                        state_q <= CHECK;
                        busy_q  <= 1'b1;
                    end
                end
                CHECK: begin
                    if (hop_bad) begin
                        blocked_q <= 1'b1;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
`ifdef HOP_QUEUE_EN
                        if (pend_valid) begin
                            dir_q     <= pend_dir;
                            q_valid_q <= 1'b0;
                            state_q   <= CHECK;
                            busy_q    <= 1'b1;
                        end
`endif
                    end else begin
                        state_q <= STEP;
                        step_q  <= '0;
                    end
                end
                STEP: begin
                    if (i_ani_stb && i_animate) begin
                        case (dir_q)
                            DIR_UP:    y_q <= y_q - STEP_U;
                            DIR_DOWN:  y_q <= y_q + STEP_U;
                            DIR_LEFT:  x_q <= x_q - STEP_U;
                            DIR_RIGHT: x_q <= x_q + STEP_U;
                            default:   y_q <= y_q;
                        endcase
                        if (step_q == LAST_CNT) begin
                            step_q  <= '0;
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            step_q <= step_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`ifdef HOP_QUEUE_EN
                    if (pend_valid) begin
                        dir_q     <= pend_dir;
                        q_valid_q <= 1'b0;
                        state_q   <= CHECK;
                        busy_q    <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_x        = x_q;
    assign o_y        = y_q;
    assign o_busy     = busy_q;
    assign o_hop_done = done_q;
    assign o_blocked  = blocked_q;
    assign o_dir      = dir_q;

endmodule

// File: tb/tb_hop_ctrl.sv
// Directed bench for hop_ctrl: hop sequence, bounds, priority, pause, mid-hop press and mid-hop reset.
module tb_hop_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_ani_stb = 1'b0;
    logic        i_animate = 1'b1;
    logic        i_up = 1'b0, i_down = 1'b0, i_left = 1'b0, i_right = 1'b0;
    logic [11:0] i_start_x = 12'd0, i_start_y = 12'd0;
    logic [11:0] o_x, o_y;
    logic        o_busy, o_hop_done, o_blocked;
    logic [1:0]  o_dir;

    int total = 0;
    int bad   = 0;

    hop_ctrl dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_ani_stb  (i_ani_stb),
        .i_animate  (i_animate),
        .i_up       (i_up),
        .i_down     (i_down),
        .i_left     (i_left),
        .i_right    (i_right),
        .i_start_x  (i_start_x),
        .i_start_y  (i_start_y),
        .o_x        (o_x),
        .o_y        (o_y),
        .o_busy     (o_busy),
        .o_hop_done (o_hop_done),
        .o_blocked  (o_blocked),
        .o_dir      (o_dir)
    );

    always #5 i_clk = ~i_clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge i_clk);
    endtask

    task automatic do_reset(input logic [11:0] sx, input logic [11:0] sy);
        i_rst_n   = 1'b0;
        i_start_x = sx;
        i_start_y = sy;
        i_ani_stb = 1'b0;
        i_animate = 1'b1;
        {i_up, i_down, i_left, i_right} = 4'b0;
        cyc();
        cyc();
        i_rst_n = 1'b1;
    endtask

    task automatic strobe();
        repeat (3) cyc();
        i_ani_stb = 1'b1;
        cyc();
        i_ani_stb = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(12'd296, 12'd432);
        total++; if (o_x !== 12'd296) begin bad++; $display("FAIL reset_x got=%0d exp=296", o_x); end
        total++; if (o_y !== 12'd432) begin bad++; $display("FAIL reset_y got=%0d exp=432", o_y); end
        total++; if ({o_busy, o_hop_done, o_blocked, o_dir} !== 5'b0) begin bad++;
            $display("FAIL reset_flags got=%b exp=00000", {o_busy, o_hop_done, o_blocked, o_dir}); end
    endtask

    task automatic test_hop_up();
        logic [11:0] exp_y [4] = '{12'd420, 12'd408, 12'd396, 12'd384};
        do_reset(12'd296, 12'd432);
        i_up = 1'b1;
        cyc();
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL up_busy_check got=%b exp=1", o_busy); end
        i_up = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            strobe();
            total++; if (o_y !== exp_y[i]) begin bad++; $display("FAIL up_y%0d got=%0d exp=%0d", i, o_y, exp_y[i]); end
        end
        total++; if (o_hop_done !== 1'b1) begin bad++; $display("FAIL up_done got=%b exp=1", o_hop_done); end
        total++; if (o_x !== 12'd296) begin bad++; $display("FAIL up_x got=%0d exp=296", o_x); end
        cyc();
        total++; if ({o_busy, o_hop_done} !== 2'b00) begin bad++; $display("FAIL up_after got=%b exp=00", {o_busy, o_hop_done}); end
    endtask

    task automatic test_blocked();
        do_reset(12'd0, 12'd0);
        i_left = 1'b1;
        cyc();
        total++; if ({o_busy, o_blocked} !== 2'b10) begin bad++; $display("FAIL blk_check got=%b exp=10", {o_busy, o_blocked}); end
        total++; if (o_dir !== 2'd2) begin bad++; $display("FAIL blk_dir got=%0d exp=2", o_dir); end
        i_left = 1'b0;
        cyc();
        total++; if ({o_busy, o_blocked, o_hop_done} !== 3'b010) begin bad++;
            $display("FAIL blk_pulse got=%b exp=010", {o_busy, o_blocked, o_hop_done}); end
        total++; if (o_x !== 12'd0) begin bad++; $display("FAIL blk_x got=%0d exp=0", o_x); end
        cyc();
        total++; if ({o_busy, o_blocked, o_hop_done} !== 3'b000) begin bad++;
            $display("FAIL blk_end got=%b exp=000", {o_busy, o_blocked, o_hop_done}); end
        for (int i = 0; i < 4; i++) strobe();
        total++; if ({o_x, o_y} !== 24'd0) begin bad++; $display("FAIL blk_pos got=%0d,%0d exp=0,0", o_x, o_y); end
    endtask

    task automatic test_bounds();
        do_reset(12'd544, 12'd0);
        i_right = 1'b1;
        cyc();
        i_right = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) strobe();
        total++; if (o_x !== 12'd592) begin bad++; $display("FAIL edge_x got=%0d exp=592", o_x); end
        cyc();
        i_right = 1'b1;
        cyc();
        i_right = 1'b0;
        cyc();
        total++; if (o_blocked !== 1'b1) begin bad++; $display("FAIL edge_blk got=%b exp=1", o_blocked); end
        total++; if (o_x !== 12'd592) begin bad++; $display("FAIL edge_hold got=%0d exp=592", o_x); end
        cyc();
        i_up = 1'b1;
        cyc();
        i_up = 1'b0;
        cyc();
        total++; if (o_blocked !== 1'b1) begin bad++; $display("FAIL top_blk got=%b exp=1", o_blocked); end
    endtask

    task automatic test_priority();
        do_reset(12'd100, 12'd200);
        i_up = 1'b1;
        i_right = 1'b1;
        cyc();
        total++; if (o_dir !== 2'd0) begin bad++; $display("FAIL prio_dir got=%0d exp=0", o_dir); end
        i_up = 1'b0;
        i_right = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) strobe();
        cyc();
        total++; if (o_y !== 12'd152) begin bad++; $display("FAIL prio_y got=%0d exp=152", o_y); end
        total++; if (o_x !== 12'd100) begin bad++; $display("FAIL prio_x got=%0d exp=100", o_x); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL prio_busy got=%b exp=0", o_busy); end
    endtask

    task automatic test_pause();
        do_reset(12'd296, 12'd432);
        i_up = 1'b1;
        cyc();
        i_up = 1'b0;
        cyc();
        strobe();
        strobe();
        total++; if (o_y !== 12'd408) begin bad++; $display("FAIL pause_pre got=%0d exp=408", o_y); end
        i_animate = 1'b0;
        for (int i = 0; i < 10; i++) strobe();
        total++; if (o_y !== 12'd408) begin bad++; $display("FAIL pause_hold got=%0d exp=408", o_y); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL pause_busy got=%b exp=1", o_busy); end
        i_animate = 1'b1;
        strobe();
        total++; if (o_y !== 12'd396) begin bad++; $display("FAIL pause_res got=%0d exp=396", o_y); end
        strobe();
        total++; if (o_y !== 12'd384) begin bad++; $display("FAIL pause_end got=%0d exp=384", o_y); end
        total++; if (o_hop_done !== 1'b1) begin bad++; $display("FAIL pause_done got=%b exp=1", o_hop_done); end
    endtask

    task automatic test_back_to_back();
        do_reset(12'd100, 12'd100);
        i_right = 1'b1;
        cyc();
        i_right = 1'b0;
        cyc();
        strobe();
        total++; if (o_x !== 12'd112) begin bad++; $display("FAIL b2b_x1 got=%0d exp=112", o_x); end
        i_right = 1'b1;
        cyc();
        i_right = 1'b0;
        for (int i = 0; i < 3; i++) strobe();
        total++; if (o_x !== 12'd148) begin bad++; $display("FAIL b2b_x4 got=%0d exp=148", o_x); end
        total++; if (o_hop_done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", o_hop_done); end
        cyc();
`ifdef HOP_QUEUE_EN
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL b2b_chain got=%b exp=1", o_busy); end
`else
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL b2b_chain got=%b exp=0", o_busy); end
`endif
        cyc();
        for (int i = 0; i < 4; i++) strobe();
        cyc();
`ifdef HOP_QUEUE_EN
        total++; if (o_x !== 12'd196) begin bad++; $display("FAIL b2b_final got=%0d exp=196", o_x); end
`else
        total++; if (o_x !== 12'd148) begin bad++; $display("FAIL b2b_final got=%0d exp=148", o_x); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset(12'd200, 12'd200);
        i_down = 1'b1;
        cyc();
        cyc();
        strobe();
        strobe();
        total++; if (o_y !== 12'd224) begin bad++; $display("FAIL rmid_pre got=%0d exp=224", o_y); end
        i_rst_n = 1'b0;
        i_ani_stb = 1'b1;
        cyc();
        i_ani_stb = 1'b0;
        total++; if (o_y !== 12'd200) begin bad++; $display("FAIL rmid_y got=%0d exp=200", o_y); end
        total++; if ({o_busy, o_hop_done} !== 2'b00) begin bad++; $display("FAIL rmid_flags got=%b exp=00", {o_busy, o_hop_done}); end
        i_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) strobe();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rmid_held got=%b exp=0", o_busy); end
        total++; if (o_y !== 12'd200) begin bad++; $display("FAIL rmid_still got=%0d exp=200", o_y); end
        i_down = 1'b0;
        cyc();
        i_down = 1'b1;
        cyc();
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL rmid_new got=%b exp=1", o_busy); end
        total++; if (o_dir !== 2'd1) begin bad++; $display("FAIL rmid_dir got=%0d exp=1", o_dir); end
        i_down = 1'b0;
    endtask

    initial begin
        cyc();
        test_reset();
        test_hop_up();
        test_blocked();
        test_bounds();
        test_priority();
        test_pause();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
